// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite scheduler: clears a line buffer, then overlays the matching ROM row
// of every character that overlaps the line (pacman lowest priority, blinky on top).
module sprite_line_fetcher #(
  parameter int LB_W   = 224,
  parameter int SPR_SZ = 16,
  parameter int PIX_W  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [9:0]              i_line,
  input  logic [9:0]              i_pacman_x,
  input  logic [9:0]              i_pacman_y,
  input  logic [9:0]              i_blinky_x,
  input  logic [9:0]              i_blinky_y,
  input  logic [9:0]              i_pinky_x,
  input  logic [9:0]              i_pinky_y,
  input  logic [9:0]              i_inky_x,
  input  logic [9:0]              i_inky_y,
  input  logic [9:0]              i_clyde_x,
  input  logic [9:0]              i_clyde_y,
  output logic                    o_rom_req,
  output logic [6:0]              o_rom_addr,
  input  logic                    i_rom_valid,
  input  logic [SPR_SZ*PIX_W-1:0] i_rom_data,
  output logic                    o_lb_we,
  output logic [7:0]              o_lb_addr,
  output logic [PIX_W-1:0]        o_lb_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overrun
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [7:0]  LAST_COL = 8'(LB_W - 1);
  localparam logic [10:0] LB_COLS  = 11'(LB_W);

  logic [2:0]                    state;
  logic [9:0]                    line_q;
  logic [4:0][9:0]               cx_q, cy_q;   // index = character id (0 pacman, 1..4 blinky..clyde)
  logic [2:0]                    seq;          // service slot, 0 = lowest priority
  logic [2:0]                    chr;
  logic [7:0]                    cnt;
  logic [SPR_SZ-1:0][PIX_W-1:0]  pix_q;
  logic [10:0]                   d, col;
  logic [PIX_W-1:0]              pix;

  // slot 0 is pacman, slots 1..4 walk clyde -> blinky so blinky lands last
  assign chr = (seq == 3'd0) ? 3'd0 : 3'd5 - seq;
  assign d   = {1'b0, line_q} - {1'b0, cx_q[chr]};
  assign col = {1'b0, cy_q[chr]} + {7'd0, cnt[3:0]};
  assign pix = pix_q[cnt[3:0]];

  assign o_rom_req = (state == S_REQ);
  assign o_busy    = (state != S_IDLE) | o_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      line_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      seq        <= '0;
      cnt        <= '0;
      pix_q      <= '0;
      o_rom_addr <= '0;
      o_lb_we    <= 1'b0;
      o_lb_addr  <= '0;
      o_lb_data  <= '0;
      o_done     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_overrun <= i_start & o_busy;
      o_lb_we   <= 1'b0;
      o_lb_addr <= '0;
      o_lb_data <= '0;
      case (state)
        S_IDLE: if (i_start && !o_done) begin
          line_q <= i_line;
          cx_q   <= {i_clyde_x, i_inky_x, i_pinky_x, i_blinky_x, i_pacman_x};
          cy_q   <= {i_clyde_y, i_inky_y, i_pinky_y, i_blinky_y, i_pacman_y};
          cnt    <= '0;
          state  <= S_CLEAR;
        end
        S_CLEAR: begin
          o_lb_we   <= 1'b1;
          o_lb_addr <= cnt;
          if (cnt == LAST_COL) begin
            cnt   <= '0;
            seq   <= '0;
            state <= S_CHECK;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_CHECK: begin
          if (d < 11'd16) begin
            o_rom_addr <= {chr, d[3:0]};
            state      <= S_REQ;
          end else if (seq == 3'd4) begin
            state <= S_DONE;
          end else begin
            seq <= seq + 3'd1;
          end
        end
        S_REQ: if (i_rom_valid) begin
          pix_q <= i_rom_data;
          cnt   <= '0;
          state <= S_WRITE;
        end
        S_WRITE: begin
          // transparent or clipped pixels still take their cycle
          if (pix != '0 && col < LB_COLS) begin
            o_lb_we   <= 1'b1;
            o_lb_addr <= col[7:0];
            o_lb_data <= pix;
          end
          if (cnt[3:0] == 4'd15) begin
            cnt <= '0;
            if (seq == 3'd4) state <= S_DONE;
            else begin
              seq   <= seq + 3'd1;
              state <= S_CHECK;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          o_done <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Randomized bench for sprite_line_fetcher: a ROM responder with variable latency and a
// line-level reference model (final buffer contents, write count, ROM order, cycle count).
module tb_sprite_line_fetcher;
  localparam int LB_W  = 224;
  localparam int PIX_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_start = 1'b0;
  logic [9:0]        line = '0;
  logic [4:0][9:0]   cx = '0, cy = '0;   // 0 pacman, 1 blinky, 2 pinky, 3 inky, 4 clyde
  logic              o_rom_req;
  logic [6:0]        o_rom_addr;
  logic              i_rom_valid = 1'b0;
  logic [63:0]       i_rom_data = '0;
  logic              o_lb_we;
  logic [7:0]        o_lb_addr;
  logic [PIX_W-1:0]  o_lb_data;
  logic              o_busy, o_done, o_overrun;

  sprite_line_fetcher #(.LB_W(LB_W), .SPR_SZ(16), .PIX_W(PIX_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_line(line),
    .i_pacman_x(cx[0]), .i_pacman_y(cy[0]), .i_blinky_x(cx[1]), .i_blinky_y(cy[1]),
    .i_pinky_x(cx[2]), .i_pinky_y(cy[2]), .i_inky_x(cx[3]), .i_inky_y(cy[3]),
    .i_clyde_x(cx[4]), .i_clyde_y(cy[4]),
    .o_rom_req(o_rom_req), .o_rom_addr(o_rom_addr), .i_rom_valid(i_rom_valid),
    .i_rom_data(i_rom_data), .o_lb_we(o_lb_we), .o_lb_addr(o_lb_addr), .o_lb_data(o_lb_data),
    .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // ROM contents and monitor state
  logic [63:0] rom_mem [128];
  logic [3:0]  lb_obs [LB_W];
  logic [6:0]  rq_q[$];
  int          lat_q[$];
  int          cyc = 0, start_cyc, done_cyc, done_cnt, ovr_cnt, wr_cnt, bad_addr, unstable;
  int          lat_fixed = -1;
  bit          armed = 0, stray_en = 0;

  initial begin : monitor
    int wc;
    bit req_act;
    logic [6:0] req_addr;
    wc = 0; req_act = 0; req_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (armed && i_start) begin start_cyc = cyc; armed = 0; end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (o_overrun) ovr_cnt++;
      if (o_lb_we) begin
        wr_cnt++;
        if (o_lb_addr < LB_W) lb_obs[o_lb_addr] = o_lb_data;
        else bad_addr++;
      end
      if (o_rom_req) begin
        if (!req_act) begin
          req_act = 1; req_addr = o_rom_addr;
          wc = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
          rq_q.push_back(o_rom_addr); lat_q.push_back(wc);
        end else if (o_rom_addr != req_addr) unstable++;
        if (wc == 0) begin i_rom_valid = 1'b1; i_rom_data = rom_mem[o_rom_addr]; end
        else begin i_rom_valid = 1'b0; i_rom_data = {$urandom, $urandom}; wc--; end
      end else begin
        req_act = 0;
        i_rom_valid = stray_en && ($urandom_range(0, 7) == 0);
        i_rom_data = {$urandom, $urandom};
      end
    end
  end

  logic [9:0]      s_ln;
  logic [4:0][9:0] s_xs, s_ys;

  task automatic fill_rom();
    for (int a = 0; a < 128; a++)
      for (int i = 0; i < 16; i++)
        rom_mem[a][4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endtask

  task automatic start_line(input logic [9:0] ln, input logic [4:0][9:0] xs, input logic [4:0][9:0] ys);
    for (int c = 0; c < LB_W; c++) lb_obs[c] = 4'hF;
    wr_cnt = 0; done_cnt = 0; ovr_cnt = 0; bad_addr = 0; unstable = 0;
    rq_q.delete(); lat_q.delete(); done_cyc = -1; start_cyc = -1;
    s_ln = ln; s_xs = xs; s_ys = ys;
    line = ln; cx = xs; cy = ys; armed = 1;
    @(posedge clk); #2; i_start = 1'b1;
    @(posedge clk); #2; i_start = 1'b0;
    // scramble inputs: the build must run from its snapshot
    line = 10'($urandom); for (int k = 0; k < 5; k++) begin cx[k] = 10'($urandom); cy[k] = 10'($urandom); end
  endtask

  // mode 0: plain, 1: extra i_start mid-build, 2: extra i_start in the done cycle
  task automatic finish_line(input int mode, input string tag);
    logic [3:0]  exp_lb [LB_W];
    logic [6:0]  exp_rq[$];
    logic [63:0] row;
    logic [10:0] d, col;
    logic [6:0]  a;
    int ord[5] = '{0, 4, 3, 2, 1};
    int budget, exp_wr, exp_lat, nbad, id;
    budget = 0;
    if (mode == 1) begin
      repeat ($urandom_range(3, 150)) @(posedge clk);
      #2; i_start = 1'b1; line = 10'($urandom);
      @(posedge clk); #2; i_start = 1'b0;
    end
    while (!o_done && budget < 5000) begin @(posedge clk); #2; budget++; end
    chk({tag, ":timeout"}, longint'(budget < 5000), 1);
    if (mode == 2) begin
      i_start = 1'b1;
      @(posedge clk); #2; i_start = 1'b0;
    end
    repeat (4) @(posedge clk);
    #2;
    for (int c = 0; c < LB_W; c++) exp_lb[c] = 4'h0;
    exp_wr = LB_W; exp_lat = 1 + LB_W + 5 + 1;
    for (int k = 0; k < 5; k++) begin
      id = ord[k];
      d = {1'b0, s_ln} - {1'b0, s_xs[id]};
      if (d < 16) begin
        a = {3'(id), d[3:0]};
        exp_rq.push_back(a);
        row = rom_mem[a];
        for (int i = 0; i < 16; i++) begin
          col = {1'b0, s_ys[id]} + 11'(i);
          if (row[4*i +: 4] != 4'h0 && col < LB_W) begin
            exp_lb[col] = row[4*i +: 4];
            exp_wr++;
          end
        end
      end
    end
    foreach (lat_q[j]) exp_lat += lat_q[j] + 1 + 16;
    nbad = bad_addr;
    for (int c = 0; c < LB_W; c++) if (lb_obs[c] !== exp_lb[c]) nbad++;
    chk({tag, ":done_pulses"}, done_cnt, 1);
    chk({tag, ":latency"}, done_cyc - start_cyc, exp_lat);
    chk({tag, ":rom_reqs"}, rq_q.size(), exp_rq.size());
    for (int j = 0; j < exp_rq.size() && j < rq_q.size(); j++)
      chk({tag, ":rom_addr"}, rq_q[j], exp_rq[j]);
    chk({tag, ":writes"}, wr_cnt, exp_wr);
    chk({tag, ":bad_cols"}, nbad, 0);
    chk({tag, ":addr_unstable"}, unstable, 0);
    chk({tag, ":overruns"}, ovr_cnt, (mode != 0) ? 1 : 0);
    chk({tag, ":busy_after"}, o_busy, 0);
  endtask

  task automatic far_coords(output logic [4:0][9:0] xs, output logic [4:0][9:0] ys);
    for (int k = 0; k < 5; k++) begin xs[k] = 10'd100; ys[k] = 10'd0; end
  endtask

  task automatic reset_mid(input int wait_cyc, input int lat, input bit in_req, input string tag);
    logic [4:0][9:0] xs, ys;
    int w;
    far_coords(xs, ys);
    xs[0] = 10'd40; ys[0] = 10'd10;
    fill_rom();
    rom_mem[{3'd0, 4'd5}] = 64'h1111_1111_1111_1111;
    lat_fixed = lat;
    start_line(10'd45, xs, ys);
    repeat (wait_cyc) @(posedge clk);
    #3;
    if (in_req) chk({tag, ":req_before"}, o_rom_req, 1);
    rst = 1'b1;
    #1;
    chk({tag, ":outs_zero"}, {o_rom_req, o_rom_addr, o_lb_we, o_lb_addr, o_lb_data, o_busy, o_done, o_overrun}, 0);
    w = wr_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ":no_writes"}, wr_cnt - w, 0);
    @(negedge clk); rst = 1'b0;
    lat_fixed = -1;
  endtask

  initial begin : stim
    logic [4:0][9:0] xs, ys;
    logic [9:0] ln;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset:outs", {o_rom_req, o_rom_addr, o_lb_we, o_lb_addr, o_lb_data, o_busy, o_done, o_overrun}, 0);
    @(negedge clk); rst = 1'b0;

    // no overlap
    fill_rom(); far_coords(xs, ys);
    start_line(10'd50, xs, ys); finish_line(0, "no_hit");

    // single pacman hit, one-pixel row, 1-cycle ROM latency
    far_coords(xs, ys); xs[0] = 10'd40; ys[0] = 10'd10;
    rom_mem[{3'd0, 4'd5}] = 64'h1; lat_fixed = 1;
    start_line(10'd45, xs, ys); finish_line(0, "pac_hit");
    chk("pac_hit:col10", lb_obs[10], 1);

    // pacman and blinky stacked: blinky must end on top
    far_coords(xs, ys); xs[0] = 10'd40; ys[0] = 10'd10; xs[1] = 10'd40; ys[1] = 10'd10;
    rom_mem[{3'd0, 4'd0}] = 64'h7777_7777_7777_7777;
    rom_mem[{3'd1, 4'd0}] = 64'h3333_3333_3333_3333;
    start_line(10'd40, xs, ys); finish_line(0, "stack");
    chk("stack:col25", lb_obs[25], 3);

    // right-edge clipping
    far_coords(xs, ys); xs[4] = 10'd60; ys[4] = 10'd216;
    rom_mem[{3'd4, 4'd0}] = 64'h5555_5555_5555_5555; lat_fixed = 0;
    start_line(10'd60, xs, ys); finish_line(0, "clip");

    // long ROM stall plus overrun mid-build, then overrun in the done cycle
    far_coords(xs, ys); xs[2] = 10'd90; ys[2] = 10'd100; lat_fixed = 10; stray_en = 1;
    start_line(10'd95, xs, ys); finish_line(1, "stall_ovr");
    lat_fixed = -1;
    start_line(10'd95, xs, ys); finish_line(2, "done_ovr");

    // async reset mid-WRITE and mid-REQ, each followed by a normal build
    reset_mid(232, 0, 0, "rst_write");
    fill_rom(); far_coords(xs, ys); xs[0] = 10'd40; ys[0] = 10'd10;
    start_line(10'd45, xs, ys); finish_line(0, "after_rst");
    reset_mid(228, 50, 1, "rst_req");

    // randomized lines
    for (int r = 0; r < 10; r++) begin
      fill_rom();
      ln = 10'($urandom_range(0, 300));
      for (int k = 0; k < 5; k++) begin
        xs[k] = ($urandom_range(0, 2) != 0) ? ln - 10'($urandom_range(0, 17)) : 10'($urandom);
        ys[k] = ($urandom_range(0, 5) != 0) ? 10'($urandom_range(0, 240)) : 10'($urandom);
      end
      start_line(ln, xs, ys);
      finish_line(($urandom_range(0, 3) == 0) ? 1 : 0, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
